// File: rtl/nios2_oci_ram_arbiter.sv
// Arbitrates the single-port OCI debug RAM between queued JTAG commands and the
// CPU debug slave port, round-robin, with JTAG address auto-increment and overrun flagging.
module nios2_oci_ram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_byteen,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} state_t;

    state_t            state_reg, state_next;
    logic              pending_reg;
    logic              op_wr_reg;
    logic [31:0]       data_reg;
    logic [ADDR_W-1:0] jtag_addr_reg;
    logic              last_jtag_reg;
    logic [31:0]       mon_reg;
    logic              error_reg;

    logic cpu_req, grant_jtag, grant_cpu, jtag_done;
    logic any_strobe, collision, busy, accept;
    logic unused;

    assign unused = ^{jdo[37:36], jdo[2:0]};

    assign cpu_req = cpu_read | cpu_write;
    // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
    assign grant_jtag = reset_n && (state_reg == IDLE) && pending_reg && (!cpu_req || !last_jtag_reg);
    assign grant_cpu  = reset_n && (state_reg == IDLE) && cpu_req && (!pending_reg || last_jtag_reg);
    assign jtag_done  = (grant_jtag && op_wr_reg) || (state_reg == JTAG_RD);

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign collision  = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
    // A strobe landing in the completion cycle of the queued op is accepted.
    assign busy   = pending_reg && !jtag_done;
    assign accept = any_strobe && !busy;

    always_comb begin
        state_next      = state_reg;
        ram_wren        = 1'b0;
        ram_rden        = 1'b0;
        ram_addr        = cpu_address;
        ram_wdata       = cpu_writedata;
        ram_byteen      = cpu_byteenable;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = 32'h0;
        case (state_reg)
            IDLE: begin
                if (grant_jtag) begin
                    ram_addr   = jtag_addr_reg;
                    ram_wdata  = data_reg;
                    ram_byteen = 4'hF;
                    ram_wren   = op_wr_reg;
                    ram_rden   = !op_wr_reg;
                    if (!op_wr_reg)
                        state_next = JTAG_RD;
                end else if (grant_cpu) begin
                    if (cpu_write) begin
                        ram_wren        = 1'b1;
                        cpu_waitrequest = 1'b0;
                    end else begin
                        ram_rden   = 1'b1;
                        state_next = CPU_RD;
                    end
                end
            end
            CPU_RD: begin
                cpu_waitrequest = 1'b0;
                if (cpu_read)
                    cpu_readdata = ram_rdata;
                state_next = IDLE;
            end
            JTAG_RD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            op_wr_reg     <= 1'b0;
            data_reg      <= 32'h0;
            jtag_addr_reg <= '0;
            last_jtag_reg <= 1'b0;
            mon_reg       <= 32'h0;
            error_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (grant_jtag)
                last_jtag_reg <= 1'b1;
            else if (grant_cpu)
                last_jtag_reg <= 1'b0;

            if (jtag_done) begin
                pending_reg <= 1'b0;
                if (AUTO_INC)
                    jtag_addr_reg <= jtag_addr_reg + 1'b1;
                if (state_reg == JTAG_RD)
                    mon_reg <= ram_rdata;
            end

            if (accept) begin
                if (take_action_ocimem_a) begin
                    jtag_addr_reg <= jdo[ADDR_W+16:17];
                    if (jdo[34]) begin
                        pending_reg <= 1'b1;
                        op_wr_reg   <= 1'b0;
                    end
                    if (jdo[35])
                        error_reg <= 1'b0;
                end else if (take_action_ocimem_b) begin
                    pending_reg <= 1'b1;
                    op_wr_reg   <= 1'b1;
                    data_reg    <= jdo[34:3];
                end else begin
                    pending_reg <= 1'b1;
                    op_wr_reg   <= 1'b0;
                end
            end

            if ((any_strobe && busy) || (accept && collision))
                error_reg <= 1'b1;
        end
    end

    assign MonDReg       = mon_reg;
    assign monitor_ready = !pending_reg;
    assign monitor_error = error_reg;
endmodule

// File: tb/tb_nios2_oci_ram_arbiter.sv
// Cycle-by-cycle vector bench for nios2_oci_ram_arbiter with a behavioural OCI RAM.
module tb_nios2_oci_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ta_a, ta_b, tna;
    logic [37:0] jdo;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteen;
    logic        ram_wren, ram_rden;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios2_oci_ram_arbiter #(.ADDR_W(8), .AUTO_INC(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
        .take_no_action_ocimem_a(tna), .jdo(jdo),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
        .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_rdata(ram_rdata),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    // OCI RAM: byte-enabled write, registered read.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_wren)
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        if (ram_rden)
            ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        a, b, n;
        logic [37:0] jdo;
        logic        rd, wr;
        logic [7:0]  caddr;
        logic [31:0] cwd;
        logic [3:0]  cbe;
        logic        e_rden, e_wren;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic        e_wait;
        logic [31:0] e_rdata, e_mon;
        logic        e_ready, e_err;
    } vec_t;

    localparam int NV = 38;
    vec_t tv [NV];

    function automatic logic [37:0] ja(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] v;
        v = '0;
        v[24:17] = a;
        v[34] = rd;
        v[35] = clr;
        return v;
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    function automatic vec_t mk(
        input logic a, b, n, input logic [37:0] j,
        input logic rd, wr, input logic [7:0] ca, input logic [31:0] cw, input logic [3:0] cb,
        input logic er, ew, input logic [7:0] ea, input logic [31:0] ewd, input logic [3:0] ebe,
        input logic ewt, input logic [31:0] erd, emon, input logic erdy, eerr);
        vec_t v;
        v.a = a; v.b = b; v.n = n; v.jdo = j;
        v.rd = rd; v.wr = wr; v.caddr = ca; v.cwd = cw; v.cbe = cb;
        v.e_rden = er; v.e_wren = ew; v.e_addr = ea; v.e_wd = ewd; v.e_be = ebe;
        v.e_wait = ewt; v.e_rdata = erd; v.e_mon = emon; v.e_ready = erdy; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        ta_a = 0; ta_b = 0; tna = 0; jdo = '0;
        cpu_read = 0; cpu_write = 0; cpu_address = 8'h00;
        cpu_writedata = 32'h0; cpu_byteenable = 4'h0;
    endtask

    localparam logic [31:0] DB  = 32'hDEADBEEF;
    localparam logic [31:0] M00 = 32'h10000000;
    localparam logic [31:0] M11 = 32'h10000011;
    localparam logic [31:0] M20 = 32'h10000020;
    localparam logic [31:0] M21 = 32'h10000021;
    localparam logic [31:0] M40 = 32'h10000040;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 | i;
        mem[8'h10] = DB;
        ram_rdata = 32'h0;

        //             a b n jdo                 rd wr ca     cwd           cbe   rden wren ea     ewd           ebe   wait rdata mon  rdy err
        tv[0]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,32'h0,1,0);
        tv[1]  = mk(1,0,0,ja(8'h10,1,0),      0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,32'h0,1,0);
        tv[2]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 1,0,8'h10,32'h0,       4'h0, 1,32'h0,32'h0,0,0);
        tv[3]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,32'h0,0,0);
        tv[4]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,DB,1,0);
        tv[5]  = mk(0,0,1,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,DB,1,0);
        tv[6]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 1,0,8'h11,32'h0,       4'h0, 1,32'h0,DB,0,0);
        tv[7]  = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,DB,0,0);
        tv[8]  = mk(1,0,0,ja(8'hFF,0,0),      0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M11,1,0);
        tv[9]  = mk(0,1,0,jb(32'h12345678),   0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M11,1,0);
        tv[10] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,1,8'hFF,32'h12345678,4'hF, 1,32'h0,M11,0,0);
        tv[11] = mk(0,0,1,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M11,1,0);
        tv[12] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 1,0,8'h00,32'h0,       4'h0, 1,32'h0,M11,0,0);
        tv[13] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M11,0,0);
        tv[14] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[15] = mk(0,1,0,jb(32'hAAAA0001),   1,0,8'h40,32'h0,       4'hF, 1,0,8'h40,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[16] = mk(0,1,0,jb(32'hBBBB0002),   1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 0,M40,M00,0,0);
        tv[17] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,1,8'h01,32'hAAAA0001,4'hF, 1,32'h0,M00,0,1);
        tv[18] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,1);
        tv[19] = mk(1,0,0,ja(8'h00,0,1),      0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,1);
        tv[20] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[21] = mk(1,0,1,ja(8'h30,0,0),      0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[22] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,1);
        tv[23] = mk(1,0,0,ja(8'h30,0,1),      0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,1);
        tv[24] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[25] = mk(0,0,0,38'h0,              0,1,8'h05,32'hA5A5A5A5,4'h3, 0,1,8'h05,32'hA5A5A5A5,4'h3, 0,32'h0,M00,1,0);
        tv[26] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[27] = mk(1,0,0,ja(8'h20,1,0),      1,0,8'h40,32'h0,       4'hF, 1,0,8'h40,32'h0,       4'h0, 1,32'h0,M00,1,0);
        tv[28] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 0,M40,M00,0,0);
        tv[29] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 1,0,8'h20,32'h0,       4'h0, 1,32'h0,M00,0,0);
        tv[30] = mk(0,0,1,38'h0,              1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M00,0,0);
        tv[31] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 1,0,8'h40,32'h0,       4'h0, 1,32'h0,M20,0,0);
        tv[32] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 0,M40,M20,0,0);
        tv[33] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 1,0,8'h21,32'h0,       4'h0, 1,32'h0,M20,0,0);
        tv[34] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M20,0,0);
        tv[35] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 1,0,8'h40,32'h0,       4'h0, 1,32'h0,M21,1,0);
        tv[36] = mk(0,0,0,38'h0,              1,0,8'h40,32'h0,       4'hF, 0,0,8'h00,32'h0,       4'h0, 0,M40,M21,1,0);
        tv[37] = mk(0,0,0,38'h0,              0,0,8'h00,32'h0,       4'h0, 0,0,8'h00,32'h0,       4'h0, 1,32'h0,M21,1,0);

        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mon",   -1, MonDReg, 32'h0);
        chk("rst_ready", -1, {31'h0, monitor_ready}, 32'h1);
        chk("rst_err",   -1, {31'h0, monitor_error}, 32'h0);
        chk("rst_wait",  -1, {31'h0, cpu_waitrequest}, 32'h1);
        chk("rst_en",    -1, {30'h0, ram_rden, ram_wren}, 32'h0);
        reset_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            ta_a = tv[r].a; ta_b = tv[r].b; tna = tv[r].n; jdo = tv[r].jdo;
            cpu_read = tv[r].rd; cpu_write = tv[r].wr; cpu_address = tv[r].caddr;
            cpu_writedata = tv[r].cwd; cpu_byteenable = tv[r].cbe;
            #1;
            chk("rden",   r, {31'h0, ram_rden}, {31'h0, tv[r].e_rden});
            chk("wren",   r, {31'h0, ram_wren}, {31'h0, tv[r].e_wren});
            if (tv[r].e_rden || tv[r].e_wren)
                chk("addr", r, {24'h0, ram_addr}, {24'h0, tv[r].e_addr});
            if (tv[r].e_wren) begin
                chk("wdata",  r, ram_wdata, tv[r].e_wd);
                chk("byteen", r, {28'h0, ram_byteen}, {28'h0, tv[r].e_be});
            end
            chk("wait",   r, {31'h0, cpu_waitrequest}, {31'h0, tv[r].e_wait});
            chk("rdata",  r, cpu_readdata, tv[r].e_rdata);
            chk("mon",    r, MonDReg, tv[r].e_mon);
            chk("ready",  r, {31'h0, monitor_ready}, {31'h0, tv[r].e_ready});
            chk("err",    r, {31'h0, monitor_error}, {31'h0, tv[r].e_err});
            $display("vec %0d: rden=%b wren=%b addr=%h wait=%b rdata=%h mon=%h rdy=%b err=%b",
                     r, ram_rden, ram_wren, ram_addr, cpu_waitrequest, cpu_readdata,
                     MonDReg, monitor_ready, monitor_error);
        end

        // Reset asserted while a JTAG read is in the JTAG_RD cycle, CPU write held.
        @(negedge clk);
        drive_idle();
        ta_a = 1; jdo = ja(8'h10, 1'b0 | 1'b1, 1'b0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("mid_grant", 100, {31'h0, ram_rden}, 32'h1);
        @(negedge clk);
        cpu_write = 1; cpu_address = 8'h03; cpu_writedata = 32'h55AA55AA; cpu_byteenable = 4'hF;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("mid_mon",   101 + k, MonDReg, 32'h0);
            chk("mid_ready", 101 + k, {31'h0, monitor_ready}, 32'h1);
            chk("mid_en",    101 + k, {30'h0, ram_rden, ram_wren}, 32'h0);
            chk("mid_wait",  101 + k, {31'h0, cpu_waitrequest}, 32'h1);
            $display("reset cycle %0d: mon=%h rdy=%b en=%b%b wait=%b",
                     k, MonDReg, monitor_ready, ram_rden, ram_wren, cpu_waitrequest);
            @(negedge clk);
        end
        drive_idle();
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_en",    103, {30'h0, ram_rden, ram_wren}, 32'h0);
        chk("post_ready", 103, {31'h0, monitor_ready}, 32'h1);
        chk("post_mon",   103, MonDReg, 32'h0);
        chk("post_mem",   103, mem[3], 32'h10000003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
